// File: rtl/hub75_fb_loader.sv
// hub75_fb_loader: schedules host writes, an optional clear engine and a raster pixel
// stream onto the hub75_driver write port. Clear engine enabled by HUB75_FB_LOADER_CLEAR_EN.
module hub75_fb_loader #(
  parameter int unsigned N         = 2,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 32,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = $clog2(N*HEIGHT*WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_user,
  input  logic                 s_last,
  input  logic [DATA_BITS-1:0] s_r,
  input  logic [DATA_BITS-1:0] s_g,
  input  logic [DATA_BITS-1:0] s_b,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_r,
  input  logic [DATA_BITS-1:0] host_g,
  input  logic [DATA_BITS-1:0] host_b,
  input  logic                 clear_start,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_r,
  output logic [DATA_BITS-1:0] mem_g,
  output logic [DATA_BITS-1:0] mem_b,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err
);

  localparam int unsigned ROWS   = N * HEIGHT;
  localparam int unsigned DEPTH  = ROWS * WIDTH;
  localparam int unsigned X_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned Y_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SKIP = 2'd2
`ifdef HUB75_FB_LOADER_CLEAR_EN
    , CLEAR = 2'd3
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [X_BITS-1:0]      x_q, x_d;
  logic [Y_BITS-1:0]      y_q, y_d;
  logic [ADDR_BITS-1:0]   row_base_q, row_base_d;
  logic                   we_d, busy_d, frame_done_d, err_d;
  logic [ADDR_BITS-1:0]   addr_d;
  logic [DATA_BITS-1:0]   r_d, g_d, b_d;
  logic                   beat;
  logic                   host_ok;
  logic                   x_end;

`ifdef HUB75_FB_LOADER_CLEAR_EN
  logic [ADDR_BITS-1:0]   clr_q, clr_d;
  assign s_ready = !host_we && !clear_start && (state_q != CLEAR);
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign s_ready = !host_we;
`endif

  assign beat    = s_valid && s_ready;
  assign host_ok = (32'(host_addr) < DEPTH);
  assign x_end   = (x_q == X_BITS'(WIDTH - 1));

  // Next-state and registered-output logic; priority host > clear > stream.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    we_d         = 1'b0;
    addr_d       = mem_addr;
    r_d          = mem_r;
    g_d          = mem_g;
    b_d          = mem_b;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
`ifdef HUB75_FB_LOADER_CLEAR_EN
    clr_d        = clr_q;
`endif

    if (host_we && host_ok) begin
      we_d   = 1'b1;
      addr_d = host_addr;
      r_d    = host_r;
      g_d    = host_g;
      b_d    = host_b;
    end

`ifdef HUB75_FB_LOADER_CLEAR_EN
    if (clear_start) begin
      state_d    = CLEAR;
      clr_d      = '0;
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
    end else if (state_q == CLEAR) begin
      // A host write steals the port; the counter holds for that cycle.
      if (!host_we) begin
        we_d   = 1'b1;
        addr_d = clr_q;
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        if (clr_q == ADDR_BITS'(DEPTH - 1)) begin
          state_d = IDLE;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + ADDR_BITS'(1);
        end
      end
    end else
`endif
    if (beat) begin
      case (state_q)
        RUN: begin
          if (s_user) begin
            err_d      = 1'b1;
            we_d       = 1'b1;
            addr_d     = '0;
            r_d        = s_r;
            g_d        = s_g;
            b_d        = s_b;
            x_d        = X_BITS'(1);
            y_d        = '0;
            row_base_d = '0;
          end else if (s_last && x_end) begin
            we_d   = 1'b1;
            addr_d = row_base_q + ADDR_BITS'(x_q);
            r_d    = s_r;
            g_d    = s_g;
            b_d    = s_b;
            x_d    = '0;
            if (y_q == Y_BITS'(ROWS - 1)) begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
              y_d          = '0;
              row_base_d   = '0;
            end else begin
              y_d        = y_q + Y_BITS'(1);
              row_base_d = row_base_q + ADDR_BITS'(WIDTH);
            end
          end else if (s_last || x_end) begin
            err_d   = 1'b1;
            state_d = SKIP;
          end else begin
            we_d   = 1'b1;
            addr_d = row_base_q + ADDR_BITS'(x_q);
            r_d    = s_r;
            g_d    = s_g;
            b_d    = s_b;
            x_d    = x_q + X_BITS'(1);
          end
        end
        default: begin
          // IDLE and SKIP drop everything until a start-of-frame beat.
          if (s_user) begin
            we_d       = 1'b1;
            addr_d     = '0;
            r_d        = s_r;
            g_d        = s_g;
            b_d        = s_b;
            x_d        = X_BITS'(1);
            y_d        = '0;
            row_base_d = '0;
            state_d    = RUN;
          end
        end
      endcase
    end

`ifdef HUB75_FB_LOADER_CLEAR_EN
    busy_d = (state_d == CLEAR);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_r      <= '0;
      mem_g      <= '0;
      mem_b      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
`ifdef HUB75_FB_LOADER_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_r      <= r_d;
      mem_g      <= g_d;
      mem_b      <= b_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      err        <= err_d;
`ifdef HUB75_FB_LOADER_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  end

endmodule

// File: doc/hub75_fb_loader.md
# hub75_fb_loader

Frame-buffer load controller for `hub75_driver`. It accepts a raster pixel stream with valid/ready handshake and frame/line markers, and accepts single-word host writes. It also runs an optional clear engine. It schedules all three onto the driver's single write port (`mem_we`/`mem_addr`/`mem_r`/`mem_g`/`mem_b`). It sits between the video/DMA source and the driver, in the driver's `mem_clk` domain.

## Interface
Parameters:
- `N`, 2, number of vertically stacked sub-panels (driver `N`).
- `WIDTH`, 64, pixels per row.
- `HEIGHT`, 32, rows per sub-panel; frame has `ROWS = N*HEIGHT` rows.
- `DATA_BITS`, 8, bits per colour component.
- `ADDR_BITS`, `$clog2(N*HEIGHT*WIDTH)`, memory address width.

Ports:
- `clk` in 1: single clock, equal to the driver's `mem_clk`.
- `reset` in 1: synchronous, active-high.
- `s_valid` in 1: stream beat valid.
- `s_ready` out 1: stream beat accepted when `s_valid & s_ready`.
- `s_user` in 1: first pixel of a frame.
- `s_last` in 1: last pixel of a row.
- `s_r`, `s_g`, `s_b` in `DATA_BITS` each: pixel components.
- `host_we` in 1: host single-word write strobe.
- `host_addr` in `ADDR_BITS`: host write address.
- `host_r`, `host_g`, `host_b` in `DATA_BITS` each: host write data.
- `clear_start` in 1: start clear-to-zero pulse.
- `mem_we` out 1: to driver.
- `mem_addr` out `ADDR_BITS`: to driver.
- `mem_r`, `mem_g`, `mem_b` out `DATA_BITS` each: to driver.
- `busy` out 1: clear in progress.
- `frame_done` out 1: one-cycle pulse when a complete frame has been written.
- `err` out 1: one-cycle pulse on a framing error.

## Operation
- Port priority: host > clear > stream.
  - `s_ready = !host_we && !clear_start && state != CLEAR` (combinational).
- Host write: stored at `host_addr`. If `host_addr >= N*HEIGHT*WIDTH`, no write and no error.
- State machine:
  - **IDLE**
    - Beats without `s_user` are accepted and dropped.
    - A beat with `s_user` is written at address 0; x=1, y=0, row_base=0; go to RUN.
  - **RUN**: each accepted beat writes at `row_base + x`.
    - `s_user` beat: pulse `err`; restart the frame (write at address 0, x=1, y=0).
    - `s_last` with x==WIDTH-1: write; x=0, y+=1, row_base+=WIDTH.
      - If y was ROWS-1: pulse `frame_done`, go to IDLE.
    - `s_last` with x!=WIDTH-1, or no `s_last` with x==WIDTH-1: no write, pulse `err`, go to SKIP.
    - Otherwise: write, x+=1.
  - **SKIP**: beats are dropped until an `s_user` beat, which is handled as in IDLE.
  - **CLEAR**: writes zero to addresses 0..DEPTH-1, one per cycle. A cycle with `host_we` pauses the clear; the counter holds. After the last address, go to IDLE.
- `clear_start` in any state aborts the current frame (no `err`) and enters CLEAR with counter=0. `clear_start` during CLEAR restarts the counter at 0.
- Arithmetic:
  - x is `$clog2(WIDTH)` bits; y is `$clog2(ROWS)` bits.
  - Address is a running `row_base` (ADDR_BITS, += WIDTH per row), with no multiplier.
  - Non-power-of-two WIDTH is supported.

## Timing
- All outputs are registered; `s_ready` is the only combinational output.
- Write latency: accepted beat, host write or clear step in cycle t appears as `mem_we=1` with address/data in cycle t+1.
- `frame_done` and `err` assert in t+1 of the causing beat, together with its write if any.
- Reset values:
  - state IDLE.
  - `mem_we`, `mem_addr`, `mem_r`, `mem_g`, `mem_b`, `busy`, `frame_done`, `err` all 0.
  - x, y, row_base and the clear counter all 0.
- Reset mid-frame or mid-clear: no further writes from the cycle after reset is sampled.
- `busy` is 1 from the cycle after `clear_start` through the cycle that writes address DEPTH-1; it deasserts in the following cycle.
- Clear duration with no host traffic is exactly DEPTH cycles.
- Full-rate streaming is 1 pixel/cycle with no bubbles at row or frame boundaries.

## Configuration
- `HUB75_FB_LOADER_CLEAR_EN` defined: CLEAR state, clear counter and `clear_start` handling are compiled in as above.
- Not defined: `clear_start` is ignored and removed from the `s_ready` equation, `busy` is tied 0, and the CLEAR state does not exist.

## Test plan
(N=2, WIDTH=64, HEIGHT=32, DEPTH=4096.)
- Full frame: 4096 beats, `s_user` on beat 0, `s_last` every 64th beat, `s_valid` continuous → 4096 writes at addresses 0..4095 in order; one `frame_done` with the last write; `err` never asserts.
- Short row: `s_last` on beat 10 of row 3 → no write for that beat, `err` pulse, rest dropped; a following clean frame writes from address 0.
- Host collision: `host_we` to address 100 (r=0xAA) on the same cycle as a stream beat → `s_ready=0`, host write at 100 in t+1, stream beat written one cycle later with its correct address.
- Clear: `clear_start` in IDLE with one `host_we` mid-way → 4096 zero writes plus 1 host write; `busy` high for 4097 cycles.
- Reset at pixel 2000 → `mem_we=0` from the next cycle, state IDLE; a non-`s_user` beat is dropped.
- Build without `HUB75_FB_LOADER_CLEAR_EN`, pulse `clear_start` during streaming → no effect; `busy=0`.
